instr_decode_queue: RTL
=======================

# instr_decode_queue

Parametrised successor to the combinational instruction field slicer. Buffers fetched instructions in a small FIFO with valid/ready handshakes on both sides and presents the head entry fully sliced: register fields, CSR address, XLEN-wide shift amount, sign-extended immediate and instruction format. It sits between fetch and the decode/register-read stage and absorbs back-pressure from the stage behind it.

## Interface

Parameters:
- XLEN, 32: datapath width, 32 or 64. Sets the immediate and PC widths.
- DEPTH, 2: number of FIFO entries. Must be a power of two, ≥ 2.

Ports:
- clk  in  1  the single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- flush  in  1  synchronous clear of all buffered entries.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept an entry.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  the head entry is valid.
- out_ready  in  1  the consumer takes the head entry.
- out_pc  out  XLEN  PC of the head entry.
- opcode  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- funct3  out  3  instr[14:12].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- funct7  out  7  instr[31:25].
- shamt  out  $clog2(XLEN)  instr[24:20] when XLEN=32; instr[25:20] when XLEN=64.
- csr  out  12  instr[31:20].
- imm  out  XLEN  sign-extended immediate for the decoded format.
- fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5.
- count  out  $clog2(DEPTH)+1  current occupancy.
- illegal  out  1  present only when DECODE_ILLEGAL_EN is defined.

## Operation

- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count < DEPTH). A full queue deasserts in_ready even if a pop occurs in the same cycle.
- out_valid = (count != 0).
- Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- flush takes priority over push and pop. Count and pointers go to 0, and any same-cycle push is dropped.
- Decoded outputs are combinational from the head entry. While out_valid=0, every decoded output and out_pc is forced to 0.
- Format selection by opcode:
  - R: 0x33, 0x3B.
  - I: 0x03, 0x13, 0x1B, 0x67, 0x73.
  - S: 0x23.
  - B: 0x63.
  - U: 0x37, 0x17.
  - J: 0x6F.
  - Any other opcode: fmt=R, imm=0.
- Immediate construction, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - R: 0.
- Shift-immediate instructions keep fmt=I, and their imm includes the funct7 bits. shamt is tapped independently of format.

## Timing

- Reset (rst_n=0 at a rising edge): count=0, pointers=0, storage=0. As a result out_valid=0, in_ready=1, and all decoded outputs are 0.
- Reset applied mid-operation discards all entries at that edge.
- Latency: an entry pushed at edge N is visible with out_valid=1 after edge N. There is no same-cycle bypass from input to output.
- Throughput: one push and one pop per cycle. A full queue recovers in_ready=1 in the cycle after a pop.
- out_valid and the head data stay stable until popped or flushed.
- The consumer may hold out_ready high continuously.

## Configuration

- DECODE_ILLEGAL_EN defined:
  - The illegal output exists.
  - illegal=1 when out_valid and either instr[1:0] != 2'b11 or the opcode is not in the format list.
  - illegal is 0 when out_valid=0.
- DECODE_ILLEGAL_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Structure

- Shared package decode_pkg holds:
  - the opcode localparams (OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM, OP_REG, OP_REG32, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL);
  - the fmt encoding enum fmt_e.
- One sub-module, imm_gen: purely combinational, taking instr[31:0] and producing fmt and imm[XLEN-1:0], parametrised on XLEN.
- FIFO storage, pointers, field taps and output gating live in the top module.

## Test plan

- Reset, then push 0x00C00093 (addi x1,x0,12) with out_ready=1 → next cycle out_valid=1, fmt=1, rd=1, rs1=0, imm=12, out_pc=in_pc. Popped on that edge, after which out_valid=0.
- Push 0xFE000EE3 (beq x0,x0,-4) → fmt=3, imm=0xFFFFFFFC (XLEN=32) or 0xFFFFFFFFFFFFFFFC (XLEN=64).
- Push 0x123450B7 (lui x1,0x12345) then 0x0080006F (jal x0,8) → in order: fmt=4 with imm=0x12345000, then fmt=5 with imm=8.
- DEPTH=2, out_ready=0, three back-to-back pushes → in_ready=0 after the second, count=2, third held. Then out_ready=1 for one cycle → first entry popped, third accepted the following cycle, order preserved.
- flush asserted with count=2 and in_valid=1 → count=0, out_valid=0 next cycle, pushed word discarded. Reset asserted mid-stream gives the same result.
- With DECODE_ILLEGAL_EN defined, push 0x00000000 → out_valid=1, illegal=1, fmt=0, imm=0.

Source files
------------

// File: rtl/decode_pkg.sv
// ============================================================================
// Module      : decode_pkg
// Description : Opcode constants, format encoding and opcode-recognition helper
//               shared by the instruction decode queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_IMM32  = 7'h1B;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_REG32  = 7'h3B;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  function automatic logic f_opcode_known(input logic [6:0] i_op);
    case (i_op)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM,
      OP_REG, OP_REG32, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL: f_opcode_known = 1'b1;
      default:                  f_opcode_known = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/imm_gen.sv
// ============================================================================
// Module      : imm_gen
// Description : Combinational format classifier and sign-extended immediate
//               generator for a 32-bit instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output fmt_e            o_fmt,
  output logic [XLEN-1:0] o_imm
);

  logic signed [31:0] w_imm32;

  always_comb begin
    o_fmt   = FMT_R;
    w_imm32 = '0;
    case (i_instr[6:0])
      OP_REG, OP_REG32: o_fmt = FMT_R;
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: begin
        o_fmt   = FMT_I;
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      OP_STORE: begin
        o_fmt   = FMT_S;
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      OP_BRANCH: begin
        o_fmt   = FMT_B;
        w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                   i_instr[30:25], i_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        o_fmt   = FMT_U;
        w_imm32 = {i_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        o_fmt   = FMT_J;
        w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                   i_instr[20], i_instr[30:21], 1'b0};
      end
      default: begin
        o_fmt   = FMT_R;
        w_imm32 = '0;
      end
    endcase
  end

  // Signed size cast sign-extends the 32-bit immediate to XLEN.
  assign o_imm = XLEN'(w_imm32);

endmodule

`default_nettype wire

// File: rtl/instr_decode_queue.sv
// ============================================================================
// Module      : instr_decode_queue
// Description : Valid/ready instruction FIFO presenting its head entry sliced
//               into decode fields. Optional macro DECODE_ILLEGAL_EN adds the
//               illegal-instruction flag output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decode_queue
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [6:0]               opcode,
  output logic [4:0]               rd,
  output logic [2:0]               funct3,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [6:0]               funct7,
  output logic [$clog2(XLEN)-1:0]  shamt,
  output logic [11:0]              csr,
  output logic [XLEN-1:0]          imm,
  output logic [2:0]               fmt,
  output logic [$clog2(DEPTH):0]   count
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic                     illegal
`endif
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_SW = $clog2(XLEN);

  logic [31:0]     r_instr [DEPTH];
  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_AW:0]   r_count;

  logic            w_push;
  logic            w_pop;
  logic            w_out_valid;
  logic [31:0]     w_head;
  fmt_e            w_fmt;
  logic [XLEN-1:0] w_imm;

  assign in_ready    = (r_count < (c_AW+1)'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid && in_ready;
  assign w_pop       = w_out_valid && out_ready;
  assign out_valid   = w_out_valid;
  assign count       = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_instr[r_wptr] <= in_instr;
        r_pc[r_wptr]    <= in_pc;
        r_wptr          <= r_wptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head = r_instr[r_rptr];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (w_head),
    .o_fmt   (w_fmt),
    .o_imm   (w_imm)
  );

  // Every presented field reads as zero while the queue is empty.
  always_comb begin
    out_pc = '0;
    opcode = '0;
    rd     = '0;
    funct3 = '0;
    rs1    = '0;
    rs2    = '0;
    funct7 = '0;
    shamt  = '0;
    csr    = '0;
    imm    = '0;
    fmt    = '0;
    if (w_out_valid) begin
      out_pc = r_pc[r_rptr];
      opcode = w_head[6:0];
      rd     = w_head[11:7];
      funct3 = w_head[14:12];
      rs1    = w_head[19:15];
      rs2    = w_head[24:20];
      funct7 = w_head[31:25];
      shamt  = w_head[20 +: c_SW];
      csr    = w_head[31:20];
      imm    = w_imm;
      fmt    = w_fmt;
    end
  end

`ifdef DECODE_ILLEGAL_EN
  assign illegal = w_out_valid &&
                   ((w_head[1:0] != 2'b11) || !f_opcode_known(w_head[6:0]));
`endif

endmodule

`default_nettype wire
